// File: rtl/pattern_bist_ctrl.sv
// pattern_bist_ctrl: exhaustive pattern driver with MISR compaction and golden-signature check
module pattern_bist_ctrl #(
  parameter int NUM_PI = 4,
  parameter int NUM_PO = 2,
  parameter int SETTLE = 1,
  parameter int MISR_W = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h002D,
  parameter logic [MISR_W-1:0] MISR_SEED = 16'h0000,
  parameter logic [MISR_W-1:0] GOLDEN = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [NUM_PI-1:0] pi,
  input  logic [NUM_PO-1:0] po,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [NUM_PI-1:0] pat_idx
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_PI-1:0] pat_q, pat_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [MISR_W-1:0] sig_q, sig_d, po_ext;
  logic start_run, last_pat;
  assign start_run = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_pat = (pat_q == '1);
  // state and datapath registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q <= '0;
      wcnt_q <= '0;
      sig_q <= MISR_SEED;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      wcnt_q <= wcnt_d;
      sig_q <= sig_d;
    end
  end
  // next-state: settle for SETTLE cycles, capture, stop after the last pattern
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_WAIT : state_q;
      S_WAIT: state_d = (wcnt_q == 8'(SETTLE - 1)) ? S_CAPTURE : S_WAIT;
      S_CAPTURE: state_d = last_pat ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  // datapath: run init, settle counter, MISR shift with feedback and po injection
  always_comb begin
    pat_d = pat_q;
    wcnt_d = wcnt_q;
    sig_d = sig_q;
    po_ext = '0;
    po_ext[NUM_PO-1:0] = po;
    if (start_run) begin
      pat_d = '0;
      wcnt_d = '0;
      sig_d = MISR_SEED;
    end else if (state_q == S_WAIT) begin
      wcnt_d = wcnt_q + 8'd1;
    end else if (state_q == S_CAPTURE) begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0) ^ po_ext;
      pat_d = last_pat ? pat_q : pat_q + 1'b1;
      wcnt_d = '0;
    end
  end
  // outputs decoded from state; pi comes straight from the pattern register
  always_comb begin
    busy = (state_q == S_WAIT) || (state_q == S_CAPTURE);
    done = (state_q == S_DONE);
    pass = done && (sig_q == GOLDEN);
    pi = pat_q;
    pat_idx = pat_q;
    signature = sig_q;
  end
endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// tb_pattern_bist_ctrl: directed checks of pattern sequencing, MISR signature and handshake
module tb_pattern_bist_ctrl;
  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] po;
  logic [3:0] pi, pat_idx;
  logic busy, done, pass;
  logic [15:0] signature;
  int tests = 0;
  int fails = 0;

  pattern_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pi(pi), .po(po),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_idx(pat_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; po = 2'b00;
    tick; tick;
    rst = 1'b0;
    tests++; if (pi !== 4'h0) begin fails++; $display("FAIL reset_pi got %h want 0", pi); end
    tests++; if (pat_idx !== 4'h0) begin fails++; $display("FAIL reset_pat_idx got %h want 0", pat_idx); end
    tests++; if (signature !== 16'h0000) begin fails++; $display("FAIL reset_sig got %h want 0000", signature); end
    tests++; if ({busy, done, pass} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
  endtask

  task automatic test_zero_po;
    int c;
    po = 2'b00;
    launch;
    wait_done(c);
    tests++; if (c !== 32) begin fails++; $display("FAIL zero_latency got %0d want 32", c); end
    tests++; if (signature !== 16'h0000) begin fails++; $display("FAIL zero_sig got %h want 0000", signature); end
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL zero_pass got %b want 1", pass); end
    tests++; if (pi !== 4'hF) begin fails++; $display("FAIL zero_pi_hold got %h want f", pi); end
  endtask

  task automatic test_ones_po;
    int c;
    po = 2'b01;
    launch;
    tick; tick;
    tests++; if (signature !== 16'h0001) begin fails++; $display("FAIL ones_cap1 got %h want 0001", signature); end
    tick; tick;
    tests++; if (signature !== 16'h0003) begin fails++; $display("FAIL ones_cap2 got %h want 0003", signature); end
    tick; tick;
    tests++; if (signature !== 16'h0007) begin fails++; $display("FAIL ones_cap3 got %h want 0007", signature); end
    wait_done(c);
    tests++; if (c !== 26) begin fails++; $display("FAIL ones_latency got %0d want 26", c); end
    tests++; if (signature !== 16'hFFFF) begin fails++; $display("FAIL ones_sig got %h want ffff", signature); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL ones_pass got %b want 0", pass); end
  endtask

  task automatic test_poly_feedback;
    int c;
    po = 2'b10;
    launch;
    wait_done(c);
    tests++; if (signature !== 16'hFFD3) begin fails++; $display("FAIL poly_sig got %h want ffd3", signature); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL poly_pass got %b want 0", pass); end
  endtask

  task automatic test_sequence;
    logic [3:0] exp_pi;
    po = 2'b00;
    launch;
    tests++; if (pi !== 4'h0 || busy !== 1'b1) begin fails++; $display("FAIL seq_first got pi=%h busy=%b want 0/1", pi, busy); end
    for (int k = 1; k <= 32; k++) begin
      tick;
      exp_pi = (k < 32) ? 4'(k / 2) : 4'hF;
      tests++; if (pi !== exp_pi) begin fails++; $display("FAIL seq_pi k=%0d got %h want %h", k, pi, exp_pi); end
      tests++; if (pat_idx !== exp_pi) begin fails++; $display("FAIL seq_pat_idx k=%0d got %h want %h", k, pat_idx, exp_pi); end
      tests++; if (busy !== (k < 32)) begin fails++; $display("FAIL seq_busy k=%0d got %b want %b", k, busy, k < 32); end
      tests++; if (done !== (k == 32)) begin fails++; $display("FAIL seq_done k=%0d got %b want %b", k, done, k == 32); end
    end
  endtask

  task automatic test_mid_reset;
    int c;
    po = 2'b01;
    launch;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++; if (pi !== 4'h0) begin fails++; $display("FAIL midrst_pi got %h want 0", pi); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_flags got busy=%b done=%b want 0/0", busy, done); end
    tests++; if (signature !== 16'h0000) begin fails++; $display("FAIL midrst_sig got %h want 0000", signature); end
    launch;
    wait_done(c);
    tests++; if (c !== 32) begin fails++; $display("FAIL midrst_rerun_latency got %0d want 32", c); end
    tests++; if (signature !== 16'hFFFF) begin fails++; $display("FAIL midrst_rerun_sig got %h want ffff", signature); end
  endtask

  task automatic test_back_to_back;
    int c;
    logic [15:0] first_sig;
    po = 2'b01;
    launch;
    repeat (4) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++; if (busy !== 1'b1 || pi !== 4'h2) begin fails++; $display("FAIL busy_start got busy=%b pi=%h want 1/2", busy, pi); end
    wait_done(c);
    tests++; if (c !== 27) begin fails++; $display("FAIL busy_start_latency got %0d want 27", c); end
    first_sig = signature;
    tests++; if (first_sig !== 16'hFFFF) begin fails++; $display("FAIL b2b_first_sig got %h want ffff", first_sig); end
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++; if (done !== 1'b0 || busy !== 1'b1 || pi !== 4'h0) begin fails++; $display("FAIL restart got done=%b busy=%b pi=%h want 0/1/0", done, busy, pi); end
    tests++; if (signature !== 16'h0000) begin fails++; $display("FAIL restart_seed got %h want 0000", signature); end
    wait_done(c);
    tests++; if (c !== 32) begin fails++; $display("FAIL restart_latency got %0d want 32", c); end
    tests++; if (signature !== 16'hFFFF) begin fails++; $display("FAIL restart_sig got %h want ffff", signature); end
  endtask

  initial begin
    test_reset;
    test_zero_po;
    test_ones_po;
    test_poly_feedback;
    test_sequence;
    test_mid_reset;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
